// File: rtl/sim_pkg.sv
// ============================================================================
// Module   : sim_pkg
// Purpose  : Shared types and constants for the simulation-end controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sim_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_END   = 2'd2
    } state_e;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_GOOD    = 2'd1;
    localparam logic [1:0] TRAP_BAD     = 2'd2;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return inst == EBREAK_INST;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous clear and optional saturation at max.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             sat_en_i,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !(sat_en_i && (&cnt_q))) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/sim_end_ctrl.sv
// ============================================================================
// Module   : sim_end_ctrl
// Purpose  : Detects a committed ebreak, drains the LSU and raises sticky
//            sim_end with a trap classification; adds a no-commit watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sim_end_ctrl
    import sim_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          CNT_W       = 64,
    parameter int unsigned WDOG_CYCLES = 1000000,
    parameter int unsigned DRAIN_MAX   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             commit_valid,
    input  logic [XLEN-1:0]  commit_pc,
    input  logic [31:0]      commit_inst,
    input  logic [XLEN-1:0]  commit_a0,
    input  logic             lsu_busy,
    output logic             halt_req,
    output logic             sim_end,
    output logic [1:0]       trap_code,
    output logic [XLEN-1:0]  exit_pc,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
    localparam logic [32:0]        WDOG_LAST  = 33'(WDOG_CYCLES) - 33'd1;
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cycle_q, cycle_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]    last_pc_q, last_pc_d;
    logic [XLEN-1:0]    ebreak_pc_q, ebreak_pc_d;
    logic [1:0]         code_q, code_d;
    logic [1:0]         trap_q, trap_d;
    logic [XLEN-1:0]    exit_q, exit_d;
    logic               halt_q, sim_end_q;

    logic [31:0]        wdog_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               wdog_clr, wdog_en;
    logic               drain_clr, drain_en;
    logic               wdog_expire;

    sat_counter #(.WIDTH(32)) u_wdog (
        .clk      (clock),
        .rst      (reset),
        .clr_i    (wdog_clr),
        .en_i     (wdog_en),
        .sat_en_i (1'b1),
        .cnt_o    (wdog_cnt)
    );

    sat_counter #(.WIDTH(DRAIN_W)) u_drain (
        .clk      (clock),
        .rst      (reset),
        .clr_i    (drain_clr),
        .en_i     (drain_en),
        .sat_en_i (1'b1),
        .cnt_o    (drain_cnt)
    );

    // Expiry looks at the post-increment value so END is visible exactly
    // WDOG_CYCLES cycles after the last commit.
    assign wdog_expire = (WDOG_CYCLES != 0) &&
                         (({1'b0, wdog_cnt} + 33'd1) >= WDOG_LAST);

    assign drain_clr = (state_q != ST_DRAIN);

    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        last_pc_d   = last_pc_q;
        ebreak_pc_d = ebreak_pc_q;
        code_d      = code_q;
        trap_d      = trap_q;
        exit_d      = exit_q;
        wdog_clr    = 1'b0;
        wdog_en     = 1'b0;
        drain_en    = 1'b0;
        case (state_q)
            ST_RUN: begin
                cycle_d = cycle_q + CNT_ONE;
                if (commit_valid) begin
                    instret_d = instret_q + CNT_ONE;
                    last_pc_d = commit_pc;
                    wdog_clr  = 1'b1;
                    if (is_ebreak(commit_inst)) begin
                        ebreak_pc_d = commit_pc;
                        code_d      = (commit_a0 == '0) ? TRAP_GOOD : TRAP_BAD;
                        state_d     = ST_DRAIN;
                    end
                end else begin
                    wdog_en = 1'b1;
                    if (wdog_expire) begin
                        state_d = ST_END;
                        trap_d  = TRAP_TIMEOUT;
                        exit_d  = last_pc_q;
                    end
                end
            end
            ST_DRAIN: begin
                cycle_d  = cycle_q + CNT_ONE;
                drain_en = 1'b1;
                // A drained LSU wins over the drain timeout on the same cycle.
                if (!lsu_busy) begin
                    state_d = ST_END;
                    trap_d  = code_q;
                    exit_d  = ebreak_pc_q;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_d = ST_END;
                    trap_d  = TRAP_TIMEOUT;
                    exit_d  = ebreak_pc_q;
                end
            end
            ST_END: begin
                state_d = ST_END;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cycle_q     <= '0;
            instret_q   <= '0;
            last_pc_q   <= '0;
            ebreak_pc_q <= '0;
            code_q      <= TRAP_NONE;
            trap_q      <= TRAP_NONE;
            exit_q      <= '0;
            halt_q      <= 1'b0;
            sim_end_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            last_pc_q   <= last_pc_d;
            ebreak_pc_q <= ebreak_pc_d;
            code_q      <= code_d;
            trap_q      <= trap_d;
            exit_q      <= exit_d;
            halt_q      <= (state_d != ST_RUN);
            sim_end_q   <= (state_d == ST_END);
        end
    end

    assign halt_req    = halt_q;
    assign sim_end     = sim_end_q;
    assign trap_code   = trap_q;
    assign exit_pc     = exit_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_sim_end_ctrl.sv
// ============================================================================
// Module   : tb_sim_end_ctrl
// Purpose  : Randomized scoreboard bench for sim_end_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sim_end_ctrl;

    localparam int          WDOG = 8;
    localparam int          DM   = 16;
    localparam int          MAXC = 256;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic [31:0] commit_a0;
    logic        lsu_busy;
    logic        halt_req;
    logic        sim_end;
    logic [1:0]  trap_code;
    logic [31:0] exit_pc;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    always #5 clock = ~clock;

    sim_end_ctrl #(
        .XLEN        (32),
        .CNT_W       (64),
        .WDOG_CYCLES (WDOG),
        .DRAIN_MAX   (DM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .commit_a0    (commit_a0),
        .lsu_busy     (lsu_busy),
        .halt_req     (halt_req),
        .sim_end      (sim_end),
        .trap_code    (trap_code),
        .exit_pc      (exit_pc),
        .cycle_cnt    (cycle_cnt),
        .instret_cnt  (instret_cnt)
    );

    typedef struct {
        int          s;
        int          halt_from;
        logic [1:0]  trap;
        logic [31:0] exit_pc;
        logic [63:0] instret;
        bit          no_end;
    } exp_t;

    exp_t exp_q[$];

    logic        s_cv   [MAXC];
    logic [31:0] s_pc   [MAXC];
    logic [31:0] s_inst [MAXC];
    logic [31:0] s_a0   [MAXC];
    logic        s_busy [MAXC];

    int checks   = 0;
    int failures = 0;
    int ecount;

    always @(posedge clock or posedge reset) begin
        if (reset) ecount <= 0;
        else       ecount <= ecount + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecount);
        end
    endtask

    function automatic logic [31:0] pick_inst();
        case ($urandom_range(0, 3))
            0:       return 32'h0015_0513;
            1:       return 32'h0000_0073;
            2:       return 32'h3020_0073;
            default: return 32'h0010_8093;
        endcase
    endfunction

    // Fill the per-cycle stimulus tables for one scenario.
    task automatic gen(input int ncommit, input int maxgap, input bit has_eb, input int eb_gap,
                       input logic [31:0] eb_pc, input logic [31:0] eb_a0, input int busy_len,
                       input logic [31:0] base_pc);
        int cyc = 0;
        for (int c = 0; c < MAXC; c++) begin
            s_cv[c]   = 1'b0;
            s_pc[c]   = $urandom;
            s_inst[c] = $urandom;
            s_a0[c]   = $urandom;
            s_busy[c] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < ncommit; i++) begin
            cyc += int'($urandom_range(0, maxgap));
            s_cv[cyc]   = 1'b1;
            s_pc[cyc]   = base_pc + 32'(i * 4);
            s_inst[cyc] = pick_inst();
            cyc++;
        end
        if (has_eb) begin
            cyc += eb_gap;
            s_cv[cyc]   = 1'b1;
            s_pc[cyc]   = eb_pc;
            s_inst[cyc] = EBREAK;
            s_a0[cyc]   = eb_a0;
            for (int b = 1; b <= busy_len + 1; b++) begin
                if (cyc + b < MAXC) s_busy[cyc + b] = (b <= busy_len);
            end
            for (int j = 1; j <= 6; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    s_cv[cyc + j] = 1'b1;
                    if ($urandom_range(0, 3) == 0) s_inst[cyc + j] = EBREAK;
                end
            end
        end
    endtask

    // Reference: walk the commit stream applying the end-of-run rules directly.
    function automatic exp_t model();
        exp_t        e;
        int          last = -1;
        logic [31:0] lastpc = 32'h0;
        logic [63:0] n = 64'h0;
        e.no_end = 1'b0;
        e.s = MAXC; e.halt_from = MAXC; e.trap = 2'd0; e.exit_pc = 32'h0; e.instret = 64'h0;
        for (int c = 0; c < MAXC; c++) begin
            if (c == last + WDOG) begin
                e.s = c; e.halt_from = c; e.trap = 2'd3; e.exit_pc = lastpc; e.instret = n;
                return e;
            end
            if (s_cv[c]) begin
                n++;
                lastpc = s_pc[c];
                last   = c;
                if (s_inst[c] == EBREAK) begin
                    int b = 0;
                    while (c + 1 + b < MAXC && s_busy[c + 1 + b]) b++;
                    e.s         = c + 2 + ((b < DM - 1) ? b : DM - 1);
                    e.trap      = (b >= DM) ? 2'd3 : ((s_a0[c] == 32'h0) ? 2'd1 : 2'd2);
                    e.exit_pc   = s_pc[c];
                    e.instret   = n;
                    e.halt_from = c + 1;
                    return e;
                end
            end
        end
        return e;
    endfunction

    task automatic drive_idle();
        commit_valid = 1'b0;
        commit_pc    = 32'h0;
        commit_inst  = 32'h0;
        commit_a0    = 32'h0;
        lsu_busy     = 1'b0;
    endtask

    task automatic run(input bit do_abort, input int abort_rel);
        exp_t e = model();
        int   abort_at = e.halt_from + abort_rel;
        int   len;
        if (do_abort && abort_at <= e.s) e.no_end = 1'b1;
        len = do_abort ? abort_at : e.s + 2 + int'($urandom_range(0, 2));
        if (len > MAXC - 1) len = MAXC - 1;
        @(posedge clock);
        #1 reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clock);
        exp_q.push_back(e);
        @(posedge clock);
        #1 reset = 1'b0;
        for (int k = 0; k < len; k++) begin
            commit_valid = s_cv[k];
            commit_pc    = s_pc[k];
            commit_inst  = s_inst[k];
            commit_a0    = s_a0[k];
            lsu_busy     = s_busy[k];
            @(posedge clock);
            #1;
        end
        if (do_abort) reset = 1'b1;
    endtask

    // Monitor: checks every cycle against the scenario at the queue head.
    initial begin
        exp_t cur;
        bit   active;
        bit   ended;
        active = 1'b0;
        ended  = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                if (active && !ended && !cur.no_end) begin
                    checks++;
                    failures++;
                    $display("FAIL sim_end_missing: got none expected at cycle %0d", cur.s);
                end
                active = 1'b0;
                ended  = 1'b0;
                chk("rst_halt_req", 64'(halt_req), 64'h0);
                chk("rst_sim_end", 64'(sim_end), 64'h0);
                chk("rst_trap_code", 64'(trap_code), 64'h0);
                chk("rst_exit_pc", 64'(exit_pc), 64'h0);
                chk("rst_cycle_cnt", cycle_cnt, 64'h0);
                chk("rst_instret_cnt", instret_cnt, 64'h0);
            end else begin
                if (!active && exp_q.size() > 0) begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    ended  = 1'b0;
                end
                if (active && !ended) begin
                    chk("cycle_cnt_run", cycle_cnt, 64'(ecount));
                    if (ecount < cur.s) begin
                        chk("sim_end_early", 64'(sim_end), 64'h0);
                        chk("trap_code_early", 64'(trap_code), 64'h0);
                        chk("exit_pc_early", 64'(exit_pc), 64'h0);
                        chk("halt_req", 64'(halt_req), 64'(ecount >= cur.halt_from));
                    end else begin
                        chk("sim_end_rise", 64'(sim_end), 64'h1);
                        chk("trap_code", 64'(trap_code), 64'(cur.trap));
                        chk("exit_pc", 64'(exit_pc), 64'(cur.exit_pc));
                        chk("instret_cnt", instret_cnt, cur.instret);
                        chk("halt_req_end", 64'(halt_req), 64'h1);
                        ended = 1'b1;
                    end
                end else if (active) begin
                    chk("sim_end_sticky", 64'(sim_end), 64'h1);
                    chk("cycle_cnt_frozen", cycle_cnt, 64'(cur.s));
                    chk("instret_frozen", instret_cnt, cur.instret);
                    chk("trap_code_hold", 64'(trap_code), 64'(cur.trap));
                    chk("exit_pc_hold", 64'(exit_pc), 64'(cur.exit_pc));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish by 1000000");
        $fatal(1, "bench timeout");
    end

    initial begin
        drive_idle();
        // Five addi then a clean ebreak.
        gen(5, 0, 1'b1, 0, 32'h8000_0014, 32'h0, 0, 32'h8000_0000);
        run(1'b0, 0);
        // BAD exit after a 4-cycle drain.
        gen(3, 2, 1'b1, 1, 32'h8000_0200, 32'h2A, 4, 32'h8000_0100);
        run(1'b0, 0);
        // LSU never drains.
        gen(2, 1, 1'b1, 0, 32'h8000_0300, 32'h0, 40, 32'h8000_0280);
        run(1'b0, 0);
        // Busy one cycle short of the drain limit, and exactly at it.
        gen(1, 0, 1'b1, 0, 32'h8000_0400, 32'h0, DM - 1, 32'h8000_0380);
        run(1'b0, 0);
        gen(1, 0, 1'b1, 0, 32'h8000_0440, 32'h0, DM, 32'h8000_0380);
        run(1'b0, 0);
        // Watchdog: one commit at 0x100 then idle.
        gen(1, 0, 1'b0, 0, 32'h0, 32'h0, 0, 32'h0000_0100);
        run(1'b0, 0);
        // Ebreak committed on the watchdog expiry cycle.
        gen(1, 0, 1'b1, WDOG - 2, 32'h0000_0104, 32'h0, 0, 32'h0000_0100);
        run(1'b0, 0);
        // No commits at all.
        gen(0, 0, 1'b0, 0, 32'h0, 32'h0, 0, 32'h0);
        run(1'b0, 0);
        // Reset mid-DRAIN, then a normal run.
        gen(2, 0, 1'b1, 0, 32'h8000_0500, 32'h0, 10, 32'h8000_0480);
        run(1'b1, 3);
        gen(2, 0, 1'b1, 0, 32'h8000_0600, 32'h0, 1, 32'h8000_0580);
        run(1'b0, 0);
        for (int r = 0; r < 24; r++) begin
            int          kind = int'($urandom_range(0, 4));
            logic [31:0] pc   = $urandom & 32'hFFFF_FFFC;
            logic [31:0] base = $urandom & 32'hFFFF_FFFC;
            logic [31:0] a0   = ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom;
            case (kind)
                0, 1: begin
                    gen(int'($urandom_range(0, 6)), 6, 1'b1, int'($urandom_range(0, 6)),
                        pc, a0, int'($urandom_range(0, 6)), base);
                    run(1'b0, 0);
                end
                2: begin
                    gen(int'($urandom_range(0, 3)), 6, 1'b1, int'($urandom_range(0, 3)),
                        pc, a0, int'($urandom_range(DM - 2, DM + 4)), base);
                    run(1'b0, 0);
                end
                3: begin
                    gen(int'($urandom_range(0, 5)), 10, ($urandom_range(0, 1) == 1),
                        int'($urandom_range(0, 10)), pc, a0, int'($urandom_range(0, 3)), base);
                    run(1'b0, 0);
                end
                default: begin
                    gen(int'($urandom_range(0, 4)), 3, 1'b1, 0, pc, a0, 12, base);
                    run(1'b1, int'($urandom_range(0, 8)));
                end
            endcase
        end
        @(posedge clock);
        #1 reset = 1'b1;
        drive_idle();
        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sim_end_ctrl.md
Name: sim_end_ctrl

Overview:
- CPU-side producer of the `sim_end` signal; the simulation top waits on this signal to call `$finish`.
- Monitors the retire/commit stream and detects a committed `ebreak` (32'h0010_0073).
- On `ebreak`: stalls fetch, waits for outstanding LSU traffic to drain, then raises a sticky `sim_end` with a trap classification.
- Also provides a no-commit watchdog and cycle/instret counters for end-of-run reporting.

Parameters:
- XLEN, 32, width of PC and a0.
- CNT_W, 64, width of cycle and instret counters.
- WDOG_CYCLES, 1000000, max cycles without a commit in RUN before timeout; 0 disables the watchdog.
- DRAIN_MAX, 16, max cycles spent in DRAIN before forcing a timeout end.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  XLEN  PC of the retiring instruction.
- commit_inst  in  32  encoding of the retiring instruction.
- commit_a0  in  XLEN  value of x10 after the retiring instruction.
- lsu_busy  in  1  outstanding memory transactions (stores or loads in flight).
- halt_req  out  1  stall fetch/issue; the core must commit nothing while high.
- sim_end  out  1  end of simulation; sticky until reset.
- trap_code  out  2  0 = none, 1 = GOOD (a0 == 0), 2 = BAD (a0 != 0), 3 = TIMEOUT.
- exit_pc  out  XLEN  PC of the `ebreak`, or last committed PC on timeout.
- cycle_cnt  out  CNT_W  cycles spent in RUN and DRAIN.
- instret_cnt  out  CNT_W  committed instructions, including the `ebreak`.

Behaviour:
- Reset (async, active-high): state = RUN; all outputs 0; watchdog and drain counters 0. Asserting reset mid-DRAIN or in END returns to RUN immediately.
- All outputs are registered; nothing is combinational from the inputs.
- State RUN:
  - cycle_cnt += 1 every cycle.
  - On commit_valid: instret_cnt += 1; the last PC is latched; the watchdog counter clears.
  - With no commit: watchdog += 1.
  - commit_valid && commit_inst == EBREAK at cycle N:
    - latch exit_pc = commit_pc.
    - latch code = GOOD if commit_a0 == 0, else BAD.
    - go to DRAIN; halt_req = 1 from cycle N+1.
  - WDOG_CYCLES != 0 && watchdog reaches WDOG_CYCLES - 1 with no commit:
    - go to END with trap_code = 3; exit_pc = last committed PC (0 if none).
  - Simultaneous ebreak commit and watchdog expiry: the ebreak wins, because a commit clears the watchdog.
- State DRAIN:
  - cycle_cnt += 1; halt_req = 1; the drain counter increments.
  - commit_valid is ignored: counters do not change and no re-latch occurs.
  - lsu_busy sampled 0 → END with the latched code.
  - Drain counter reaches DRAIN_MAX - 1 while lsu_busy = 1 → END with trap_code = 3; exit_pc stays at the ebreak PC.
- State END:
  - sim_end = 1, halt_req = 1; trap_code and exit_pc are driven.
  - Counters frozen. Absorbing state; only reset leaves it.
- Latency: ebreak committed at cycle N with lsu_busy = 0 at N+1 → sim_end = 1 at N+2. Minimum latency is 2 cycles.
- trap_code and exit_pc change to final values in the same cycle sim_end rises; before that they read 0.
- Counters wrap modulo 2^CNT_W. The watchdog counter is 32 bits and saturates.
- Non-ebreak SYSTEM encodings (ecall, mret) get no special handling.

Decomposition:
- Shared package `sim_pkg`:
  - state enum {RUN, DRAIN, END}.
  - trap_code constants TRAP_NONE/GOOD/BAD/TIMEOUT.
  - EBREAK_INST = 32'h0010_0073.
- One natural sub-module: `sat_counter` (width parameter, clear, enable, saturate flag), instantiated for the watchdog and drain counters.
- The 64-bit counters stay inline.

Test Plan:
- Reset, then 5 commits (addi), then ebreak at pc 0x8000_0014 with a0 = 0, lsu_busy = 0 → sim_end high 2 cycles after the ebreak commit; trap_code = 1, exit_pc = 0x8000_0014, instret_cnt = 6.
- ebreak with a0 = 0x2A while lsu_busy stays high for 4 cycles → halt_req high the cycle after commit; sim_end rises the cycle after lsu_busy falls; trap_code = 2.
- ebreak with lsu_busy stuck high, DRAIN_MAX = 16 → sim_end after 16 DRAIN cycles; trap_code = 3, exit_pc = ebreak PC.
- WDOG_CYCLES = 8, one commit at pc 0x100, then idle → sim_end 8 cycles after the last commit; trap_code = 3, exit_pc = 0x100. A commit on the expiry cycle that is an ebreak → trap_code = 1.
- Assert reset 2 cycles after sim_end, then release → all outputs 0; a second ebreak run completes normally with counters restarted from 0.
- Commit pulses injected during DRAIN → instret_cnt and exit_pc unchanged; cycle_cnt frozen once in END.
